// File: rtl/game_scoreboard.sv
// ---------------------------------------------------------------------------
// game_scoreboard
//
// This module keeps the score and the remaining lives for an asteroid-dodging
// game. Every asteroid instance reports two pulses: one when it passes the
// bottom of the screen, and one when it hits the ship. The score is a 4-digit
// BCD counter that saturates at 9999. Lives and the post-hit grace period are
// tracked by a four-state controller: READY, PLAY, GRACE and OVER.
//
// All inputs except rst are sampled only on clk edges where pixpulse=1.
// Registered outputs update on those same edges. An event therefore appears
// on the outputs one clk after the pixpulse edge that sampled it.
//
// Optional feature macro: SCOREBOARD_LIVES_EN
//   defined   : collisions cost lives, with GRACE and OVER states.
//   undefined : collisions are ignored and only READY/PLAY are reachable.
//               lives is tied to START_LIVES; life_lost and game_over are 0.
//
// Parameters
//   NUM_SRC      number of asteroid sources (1..9)
//   START_LIVES  lives loaded when a game starts (1..7)
//   GRACE_FRAMES invulnerability length after a hit, in move frames (1..255)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset (acts on any clk edge)
//   pixpulse   in   pixel-rate enable, qualifies every other input
//   move       in   frame tick (counted only when pixpulse is high)
//   start      in   level: begin a game in READY; must drop to leave OVER
//   score_inc  in   per-source "passed the bottom" pulses
//   collision  in   per-source ship-hit pulses
//   score_bcd  out  four BCD digits, [3:0] is the units digit
//   lives      out  remaining lives
//   state      out  READY=0, PLAY=1, GRACE=2, OVER=3
//   life_lost  out  one-pixpulse-period pulse when a life is deducted
//   game_over  out  high while in OVER
// ---------------------------------------------------------------------------
module game_scoreboard #(
  parameter int NUM_SRC      = 4,
  parameter int START_LIVES  = 3,
  parameter int GRACE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixpulse,
  input  logic               move,
  input  logic               start,
  input  logic [NUM_SRC-1:0] score_inc,
  input  logic [NUM_SRC-1:0] collision,
  output logic [15:0]        score_bcd,
  output logic [2:0]         lives,
  output logic [1:0]         state,
  output logic               life_lost,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_PLAY  = 2'd1,
    S_GRACE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;

`ifdef SCOREBOARD_LIVES_EN
  localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);

  logic [2:0]  lives_q, lives_d;
  logic [7:0]  grace_q, grace_d;
  logic        life_lost_q, life_lost_d;
`else
  logic        unused_inputs;
  assign unused_inputs = ^{collision, move};
`endif

  // Count the set bits. NUM_SRC is at most 9, so 4 bits are enough.
  function automatic logic [3:0] popcount(input logic [NUM_SRC-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Add n (0..9) to a 4-digit BCD value, one digit at a time, with decimal
  // carry. A carry out of the thousands digit means the true sum is above
  // 9999, so the result pins to 9999 and never wraps.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] s,
                                               input logic [3:0]  n);
    logic [15:0] r;
    logic [4:0]  sum;
    logic [3:0]  carry;
    r     = '0;
    carry = n;
    for (int i = 0; i < 4; i++) begin
      sum = {1'b0, s[4*i +: 4]} + {1'b0, carry};
      if (sum > 5'd9) begin
        r[4*i +: 4] = 4'(sum - 5'd10);
        carry       = 4'd1;
      end else begin
        r[4*i +: 4] = sum[3:0];
        carry       = 4'd0;
      end
    end
    if (carry != 4'd0) begin
      r = 16'h9999;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    score_d = score_q;
`ifdef SCOREBOARD_LIVES_EN
    lives_d     = lives_q;
    grace_d     = grace_q;
    life_lost_d = 1'b0;
`endif

    // Scoring runs in both live states. A fatal hit on the same edge still
    // gets its increment, because the score update does not depend on the
    // state transition below.
    if (state_q == S_PLAY || state_q == S_GRACE) begin
      score_d = bcd_add_sat(score_q, popcount(score_inc));
    end

    case (state_q)
      S_READY: begin
        if (start) begin
          state_d = S_PLAY;
          score_d = '0;
`ifdef SCOREBOARD_LIVES_EN
          lives_d = LIVES_INIT;
`endif
        end
      end

      S_PLAY: begin
`ifdef SCOREBOARD_LIVES_EN
        // Any number of simultaneous hits costs exactly one life.
        if (|collision) begin
          life_lost_d = 1'b1;
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            grace_d = GRACE_INIT;
            state_d = S_GRACE;
          end else begin
            lives_d = 3'd0;
            state_d = S_OVER;
          end
        end
`endif
      end

`ifdef SCOREBOARD_LIVES_EN
      S_GRACE: begin
        // Collisions are ignored here. Leave on the move frame that takes
        // the counter to zero.
        if (move) begin
          if (grace_q <= 8'd1) begin
            grace_d = 8'd0;
            state_d = S_PLAY;
          end else begin
            grace_d = grace_q - 8'd1;
          end
        end
      end

      S_OVER: begin
        // A held start must be released before another game can begin.
        if (!start) begin
          state_d = S_READY;
        end
      end
`endif

      default: state_d = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_READY;
      score_q <= '0;
`ifdef SCOREBOARD_LIVES_EN
      lives_q     <= LIVES_INIT;
      grace_q     <= '0;
      life_lost_q <= 1'b0;
`endif
    end else if (pixpulse) begin
      state_q <= state_d;
      score_q <= score_d;
`ifdef SCOREBOARD_LIVES_EN
      lives_q     <= lives_d;
      grace_q     <= grace_d;
      life_lost_q <= life_lost_d;
`endif
    end
  end

  assign state     = state_q;
  assign score_bcd = score_q;

`ifdef SCOREBOARD_LIVES_EN
  assign lives     = lives_q;
  assign life_lost = life_lost_q;
  assign game_over = (state_q == S_OVER);
`else
  assign lives     = LIVES_INIT;
  assign life_lost = 1'b0;
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_game_scoreboard.sv
module tb_game_scoreboard;

  localparam int NUM_SRC      = 4;
  localparam int START_LIVES  = 3;
  localparam int GRACE_FRAMES = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixpulse = 1'b0;
  logic        move = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  score_inc = '0;
  logic [3:0]  collision = '0;
  logic [15:0] score_bcd;
  logic [2:0]  lives;
  logic [1:0]  state;
  logic        life_lost;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  game_scoreboard #(
    .NUM_SRC(NUM_SRC),
    .START_LIVES(START_LIVES),
    .GRACE_FRAMES(GRACE_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pixpulse(pixpulse),
    .move(move),
    .start(start),
    .score_inc(score_inc),
    .collision(collision),
    .score_bcd(score_bcd),
    .lives(lives),
    .state(state),
    .life_lost(life_lost),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Behavioural model: the score is a plain integer clamped to 9999, and
  // lives are a plain integer. The model state changes once per sampled
  // pixpulse edge, or at any edge where rst is high.
  typedef struct packed {
    int   st;
    int   score;
    int   lv;
    int   grace;
    logic ll;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic r, logic pp,
                                        logic st_in, logic mv,
                                        logic [3:0] inc, logic [3:0] col);
    model_t n;
    int add;
    n = cur;
    if (r) begin
      n.st = 0; n.score = 0; n.lv = START_LIVES; n.grace = 0; n.ll = 1'b0;
      return n;
    end
    if (!pp) return n;
    add  = $countones(inc);
    n.ll = 1'b0;
    if (cur.st == 1 || cur.st == 2)
      n.score = (cur.score + add > 9999) ? 9999 : cur.score + add;
    case (cur.st)
      0: if (st_in) begin n.st = 1; n.score = 0; n.lv = START_LIVES; end
      1: begin
`ifdef SCOREBOARD_LIVES_EN
        if (col != 4'd0) begin
          n.ll = 1'b1;
          n.lv = cur.lv - 1;
          if (n.lv > 0) begin n.st = 2; n.grace = GRACE_FRAMES; end
          else begin n.lv = 0; n.st = 3; end
        end
`else
        n.lv = cur.lv + 0 * col;
`endif
      end
      2: if (mv) begin
        n.grace = cur.grace - 1;
        if (n.grace <= 0) begin n.grace = 0; n.st = 1; end
      end
      3: if (!st_in) n.st = 0;
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst, pixpulse, start, move, score_inc, collision);

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_state", 32'(state), 32'(m.st));
      check("m_score", 32'(score_bcd), 32'(to_bcd(m.score)));
      check("m_lives", 32'(lives), 32'(m.lv));
      check("m_life_lost", 32'(life_lost), 32'(m.ll));
      check("m_game_over", 32'(game_over), (m.st == 3) ? 32'd1 : 32'd0);
    end
  end

  // Each step is one pixpulse period of four clocks. When pp=1, pixpulse is
  // high for the first clock only. The inputs are held for all four clocks.
  task automatic step(input bit pp, input bit st, input logic [3:0] inc,
                      input logic [3:0] col, input bit mv);
    @(negedge clk);
    start = st; score_inc = inc; collision = col; move = mv; pixpulse = pp;
    @(negedge clk);
    pixpulse = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 4'h0, 4'h0, 0);
    chk_en = 1'b1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_score", 32'(score_bcd), 32'h0000);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_life_lost", 32'(life_lost), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;

    // With no pixpulse, start and the other inputs must be ignored.
    step(0, 1, 4'hF, 4'hF, 1);
    check("no_pix_start", 32'(state), 32'd0);

    step(1, 1, 4'h0, 4'h0, 0);
    check("start_state", 32'(state), 32'd1);
    check("start_lives", 32'(lives), 32'd3);
    check("start_score", 32'(score_bcd), 32'h0000);

    step(1, 0, 4'b1011, 4'h0, 0);
    check("inc_1011", 32'(score_bcd), 32'h0003);
    step(1, 0, 4'b1111, 4'h0, 0);
    step(1, 0, 4'b0011, 4'h0, 0);
    check("score_9", 32'(score_bcd), 32'h0009);
    step(1, 0, 4'b0001, 4'h0, 0);
    check("carry_10", 32'(score_bcd), 32'h0010);
    step(1, 0, 4'b1111, 4'h0, 0);
    check("score_14", 32'(score_bcd), 32'h0014);

    // Raise the score from 14 to 9998 in steps of 4.
    repeat (2496) step(1, 0, 4'hF, 4'h0, 0);
    check("preload_9998", 32'(score_bcd), 32'h9998);
    step(1, 0, 4'hF, 4'h0, 0);
    check("sat_9999", 32'(score_bcd), 32'h9999);
    step(1, 0, 4'b0001, 4'h0, 0);
    check("sat_hold", 32'(score_bcd), 32'h9999);

    // Reset on a clock edge where pixpulse is low.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_score", 32'(score_bcd), 32'h0000);
    check("midrst_lives", 32'(lives), 32'd3);
    repeat (3) @(negedge clk);

    // Reset that coincides with a pixpulse carrying events.
    rst = 1'b1;
    step(1, 1, 4'hF, 4'hF, 1);
    rst = 1'b0;
    check("pixrst_state", 32'(state), 32'd0);
    check("pixrst_score", 32'(score_bcd), 32'h0000);

    step(1, 1, 4'h0, 4'h0, 0);
    check("restart_state", 32'(state), 32'd1);

`ifdef SCOREBOARD_LIVES_EN
    step(1, 0, 4'b0001, 4'h0, 0);
    step(1, 0, 4'h0, 4'b0110, 0);
    check("hit1_lives", 32'(lives), 32'd2);
    check("hit1_pulse", 32'(life_lost), 32'd1);
    check("hit1_state", 32'(state), 32'd2);
    step(1, 0, 4'h0, 4'h0, 0);
    check("hit1_pulse_end", 32'(life_lost), 32'd0);
    for (int i = 0; i < 59; i++) begin
      step(1, 0, 4'h0, 4'hF, 1);
      step(1, 0, 4'h0, 4'hF, 0);
      step(0, 0, 4'h0, 4'hF, 1);
    end
    check("grace59_state", 32'(state), 32'd2);
    check("grace59_lives", 32'(lives), 32'd2);
    step(1, 0, 4'h0, 4'h0, 1);
    check("grace60_state", 32'(state), 32'd1);

    step(1, 0, 4'h0, 4'b0001, 0);
    check("hit2_lives", 32'(lives), 32'd1);
    repeat (60) step(1, 0, 4'h0, 4'h0, 1);
    check("grace2_state", 32'(state), 32'd1);

    step(1, 0, 4'b0001, 4'b1000, 0);
    check("fatal_score", 32'(score_bcd), 32'h0002);
    check("fatal_state", 32'(state), 32'd3);
    check("fatal_lives", 32'(lives), 32'd0);
    check("fatal_go", 32'(game_over), 32'd1);
    check("fatal_pulse", 32'(life_lost), 32'd1);
    repeat (3) step(1, 1, 4'hF, 4'hF, 1);
    check("over_hold_state", 32'(state), 32'd3);
    check("over_hold_score", 32'(score_bcd), 32'h0002);
    check("over_lives", 32'(lives), 32'd0);
    step(1, 0, 4'h0, 4'h0, 0);
    check("over_ready", 32'(state), 32'd0);
    check("ready_score", 32'(score_bcd), 32'h0002);

    step(1, 1, 4'h0, 4'h0, 0);
    step(1, 0, 4'h0, 4'b1111, 0);
    check("g3_state", 32'(state), 32'd2);
    repeat (5) step(1, 0, 4'b0001, 4'h0, 1);
    check("g3_score", 32'(score_bcd), 32'h0005);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("grst_state", 32'(state), 32'd0);
    check("grst_lives", 32'(lives), 32'd3);
    check("grst_score", 32'(score_bcd), 32'h0000);
    repeat (3) @(negedge clk);
`else
    step(1, 0, 4'b0001, 4'b1111, 0);
    check("nolives_state", 32'(state), 32'd1);
    check("nolives_lives", 32'(lives), 32'd3);
    check("nolives_pulse", 32'(life_lost), 32'd0);
    check("nolives_score", 32'(score_bcd), 32'h0001);
    repeat (3) step(1, 0, 4'h0, 4'hF, 1);
    check("nolives_play", 32'(state), 32'd1);
    check("nolives_go", 32'(game_over), 32'd0);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
GAME_SCOREBOARD -- requirements
Module: game_scoreboard

Interface
REQ-001 The block SHALL be clocked by one clock, clk, and SHALL use a synchronous active-high reset, rst, sampled only on the rising edge of clk.
REQ-002 Parameter NUM_SRC, default 4: number of asteroid instances feeding the block (1..9).
REQ-003 Parameter START_LIVES, default 3: lives loaded at game start (1..7).
REQ-004 Parameter GRACE_FRAMES, default 60: length of post-hit invulnerability, in move frames (1..255).
REQ-005 The ports SHALL be:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous active-high reset.
- pixpulse  in  1  pixel-rate enable, high every 4th clk.
- move  in  1  frame tick, qualified by pixpulse.
- start  in  1  level input that begins or restarts a game.
- score_inc  in  NUM_SRC  per-asteroid "passed the bottom" pulses.
- collision  in  NUM_SRC  per-asteroid ship-hit pulses.
- score_bcd  out  16  four BCD digits; [3:0] is the units digit.
- lives  out  3  remaining lives.
- state  out  2  READY=0, PLAY=1, GRACE=2, OVER=3.
- life_lost  out  1  one-pixpulse-cycle pulse when a life is deducted.
- game_over  out  1  high while state is OVER.

Function
REQ-006 Inputs other than rst SHALL be sampled only on clk edges where pixpulse=1, and all registered outputs SHALL change only on those edges.
REQ-007 Latency: an event sampled on a pixpulse edge SHALL be visible on the outputs on the next clk.
REQ-008 The state machine SHALL perform these transitions:
- READY->PLAY when start=1: score_bcd=0, lives=START_LIVES.
- PLAY->GRACE on any collision bit when lives>1: lives-1, grace counter=GRACE_FRAMES.
- PLAY->OVER on any collision bit when lives=1: lives=0.
- GRACE->PLAY when the grace counter reaches 0.
- OVER->READY when start=0.
REQ-009 Any number of simultaneous collision bits SHALL deduct exactly one life.
REQ-010 In GRACE, collisions SHALL be ignored.
REQ-011 The grace counter SHALL decrement only on pixpulse&move.
REQ-012 life_lost SHALL pulse for one pixpulse cycle on each PLAY->GRACE or PLAY->OVER transition.
REQ-013 In PLAY and GRACE, score SHALL increase by the population count of score_inc, added in BCD with decimal carry across all four digits.
REQ-014 The score SHALL saturate at 9999 and SHALL never wrap.
REQ-015 In READY and OVER, score_inc SHALL be ignored, and score_bcd SHALL hold its last value so the final score remains displayable.
REQ-016 When a score increment and a fatal collision are sampled together, the increment SHALL be applied and then the state SHALL go to OVER.
REQ-017 start held high through OVER SHALL NOT restart the game; a 0 sample in OVER is required before READY.
REQ-018 lives SHALL never underflow below 0.

Reset
REQ-019 On rst: state=READY, score_bcd=16'h0000, lives=START_LIVES, life_lost=0, game_over=0, grace counter=0.
REQ-020 rst asserted mid-game, on any clk regardless of pixpulse, SHALL take effect on that edge and discard any in-flight event.

Configuration
REQ-021 Macro SCOREBOARD_LIVES_EN SHALL select whether lives are tracked.
REQ-022 With SCOREBOARD_LIVES_EN defined: full lives/GRACE/OVER behaviour as specified above.
REQ-023 Without SCOREBOARD_LIVES_EN:
- collision inputs are ignored and the GRACE and OVER states are unreachable.
- lives is tied to START_LIVES, life_lost is tied to 0, and game_over is tied to 0.
- scoring is unchanged.

Verification
REQ-024 Reset then start=1 for one pixpulse -> state=PLAY, lives=3, score_bcd=0000.
REQ-025 In PLAY, score_inc=4'b1011 on one pixpulse -> score_bcd=0003; repeat from 0009 with 4'b0001 -> 0010.
REQ-026 Preload to 9998, score_inc=4'b1111 -> score_bcd=9999; further increments -> 9999.
REQ-027 collision=4'b0110 in PLAY -> lives=2, life_lost for one pixpulse, state=GRACE; collision during the next 59 move frames -> no change; after 60 frames -> PLAY.
REQ-028 Three separated collisions -> lives=0, state=OVER, game_over=1; score_inc ignored; start held 1 -> stays OVER; start=0 -> READY.
REQ-029 Fatal collision and score_inc=4'b0001 on the same pixpulse -> score+1 and OVER; rst mid-GRACE -> READY, lives=3, score 0000 next clk.
